// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared types and constants for the immediate extension unit.
//   ext_sel_t : decoded extension-mode selector (3 bits)
//   state_t   : control states of imm_ext_unit
//   CHUNK_W   : width of one wide-immediate beat
//   FIELD_W   : width of the instruction immediate field
// Optional feature macro: IMM_EXT_WIDE_EN (adds the ACCUM state for wide immediates).
package imm_ext_pkg;

  localparam int unsigned CHUNK_W = 16;
  localparam int unsigned FIELD_W = 29;

  typedef enum logic [2:0] {
    SelZext12 = 3'b000,
    SelZext19 = 3'b001,
    SelZext29 = 3'b010,
    SelSext12 = 3'b011,
    SelSext19 = 3'b100,
    SelWide   = 3'b101,
    SelRsvd6  = 3'b110,
    SelRsvd7  = 3'b111
  } ext_sel_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
`ifdef IMM_EXT_WIDE_EN
    StAccum = 2'd1,
`endif
    StHold  = 2'd2
  } state_t;

endpackage

// File: rtl/imm_ext_decode.sv
// imm_ext_decode: combinational single-field immediate extension.
//   value        : instruction immediate field (FIELD_W bits)
//   ext_selector : extension mode
//   result       : N-bit extended value; the wide mode and reserved codes yield 0
module imm_ext_decode
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic [FIELD_W-1:0] value,
  input  logic [2:0]         ext_selector,
  output logic [N-1:0]       result
);

  always_comb begin
    result = '0;
    case (ext_sel_t'(ext_selector))
      SelZext12: result = {{(N - 12){1'b0}}, value[13:2]};
      SelZext19: result = {{(N - 19){1'b0}}, value[18:0]};
      SelZext29: result = {{(N - 29){1'b0}}, value[28:0]};
      SelSext12: result = {{(N - 12){value[13]}}, value[13:2]};
      SelSext19: result = {{(N - 19){value[18]}}, value[18:0]};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// imm_ext_unit: registered immediate extension with optional wide-immediate accumulation.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : request handshake (ready in IDLE and ACCUM)
//   value, ext_selector, last: immediate field, mode, final wide beat marker
//   flush                    : abort current operation, return to IDLE
//   out_valid / out_ready    : result handshake (valid in HOLD)
//   extended, overflow       : N-bit result, wide immediate exceeded N bits
// Optional feature macro: IMM_EXT_WIDE_EN. When undefined, selector 101 is reserved
// (result 0), there is no ACCUM state/accumulator/beat counter and overflow is tied to 0.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] value,
  input  logic [2:0]         ext_selector,
  input  logic               last,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       extended,
  output logic               overflow
);

  state_t         state_q, state_d;
  logic [N-1:0]   dec_result;
  logic [N-1:0]   ext_q, ext_d;
  logic           accept;
  logic           is_wide;

  imm_ext_decode #(
    .N(N)
  ) u_decode (
    .value        (value),
    .ext_selector (ext_selector),
    .result       (dec_result)
  );

  // Flush wins over in_valid: nothing is accepted on a flush cycle.
  assign accept = in_valid & in_ready & ~flush;

`ifdef IMM_EXT_WIDE_EN
  localparam int unsigned   CNT_W    = $clog2(N / CHUNK_W) + 1;
  localparam logic [CNT_W-1:0] BeatsMax = CNT_W'(N / CHUNK_W);

  logic [N-1:0]     acc_q, acc_d, acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             ovf_q, ovf_d;

  assign is_wide  = (ext_sel_t'(ext_selector) == SelWide);
  // Older chunks fall off the top once more than N/16 beats arrive.
  assign acc_next = {acc_q[N-CHUNK_W-1:0], value[CHUNK_W-1:0]};
  // Saturate so a long burst keeps reporting overflow.
  assign cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
`else
  logic unused_last;
  assign unused_last = last;
  assign is_wide     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: begin
        if (accept) begin
          state_d = StHold;
`ifdef IMM_EXT_WIDE_EN
          if (is_wide && !last) state_d = StAccum;
`endif
        end
      end
    endcase
    if (flush) state_d = StIdle;
  end

  // Datapath next-state
  always_comb begin
    ext_d = ext_q;
    if (accept && !is_wide) ext_d = dec_result;
`ifdef IMM_EXT_WIDE_EN
    ovf_d = ovf_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (is_wide) begin
        acc_d = acc_next;
        cnt_d = cnt_next;
        if (last) begin
          ext_d = acc_next;
          ovf_d = (cnt_next > BeatsMax);
          acc_d = '0;
          cnt_d = '0;
        end
      end else begin
        // A non-wide request terminates any pending accumulation.
        ovf_d = 1'b0;
        acc_d = '0;
        cnt_d = '0;
      end
    end
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= '0;
`ifdef IMM_EXT_WIDE_EN
      ovf_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      ext_q <= ext_d;
`ifdef IMM_EXT_WIDE_EN
      ovf_q <= ovf_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q != StHold);
    out_valid = (state_q == StHold);
    extended  = ext_q;
`ifdef IMM_EXT_WIDE_EN
    overflow  = ovf_q;
`else
    overflow  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_imm_ext_unit.sv
// tb_imm_ext_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_imm_ext_unit;

  localparam int unsigned N     = 64;
  localparam int unsigned BEATS = N / 16;
`ifdef IMM_EXT_WIDE_EN
  localparam bit WIDE = 1'b1;
`else
  localparam bit WIDE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, last, flush, out_ready;
  logic [28:0]   value;
  logic [2:0]    ext_selector;
  logic          in_ready, out_valid, overflow;
  logic [N-1:0]  extended;

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  // Behavioural model state
  bit            m_hold;
  logic [N-1:0]  m_ext;
  bit            m_ovf;
  logic [15:0]   m_beats[$];

  imm_ext_unit #(
    .N(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .value        (value),
    .ext_selector (ext_selector),
    .last         (last),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .extended     (extended),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [N-1:0] ref_ext(input logic [2:0] sel, input logic [28:0] v);
    logic [11:0] f12;
    logic [18:0] f19;
    f12 = v[13:2];
    f19 = v[18:0];
    case (sel)
      3'd0:    return N'(f12);
      3'd1:    return N'(f19);
      3'd2:    return N'(v);
      3'd3:    return N'($signed(f12));
      3'd4:    return N'($signed(f19));
      default: return '0;
    endcase
  endfunction

  // Result of a completed wide immediate: the most recent BEATS chunks, newest lowest.
  function automatic logic [N-1:0] fold_beats();
    logic [N-1:0] r = '0;
    int sz = m_beats.size();
    for (int i = 0; i < sz; i++) begin
      int k = sz - 1 - i;
      if (k < BEATS) r[k*16 +: 16] = m_beats[i];
    end
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_hold = 0; m_ext = '0; m_ovf = 0; m_beats.delete();
    end else if (flush) begin
      m_hold = 0; m_beats.delete();
    end else if (m_hold) begin
      if (out_ready) m_hold = 0;
    end else if (in_valid) begin
      if (WIDE && ext_selector == 3'd5) begin
        m_beats.push_back(value[15:0]);
        if (last) begin
          m_ext = fold_beats();
          m_ovf = (m_beats.size() > BEATS);
          m_hold = 1;
          m_beats.delete();
        end
      end else begin
        m_ext = ref_ext(ext_selector, value);
        m_ovf = 0;
        m_hold = 1;
        m_beats.delete();
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model on the edge, settle 1 time unit after.
  task automatic cyc(input logic iv, input logic [2:0] s, input logic [28:0] v, input logic l,
                     input logic ordy, input logic fl, input logic r);
    in_valid = iv; ext_selector = s; value = v; last = l;
    out_ready = ordy; flush = fl; rst = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic release_result();
    cyc(1'b0, 3'd0, 29'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("out_valid", 64'(out_valid), 64'(m_hold));
        chk("in_ready", 64'(in_ready), 64'(!m_hold));
        if (m_hold) begin
          chk("extended", 64'(extended), 64'(m_ext));
          chk("overflow", 64'(overflow), 64'(m_ovf));
        end
      end
    end
  end

  initial begin
    logic [2:0] s;
    int unsigned r;
    in_valid = 0; ext_selector = 0; value = 0; last = 0;
    out_ready = 0; flush = 0; rst = 1;

    // Reset
    cyc(1'b0, 3'd0, 29'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 29'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checking = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_extended", 64'(extended), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // Zero-extend 12-bit field, one-cycle latency
    cyc(1'b1, 3'd0, 29'h3FFC, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("zext12_valid", 64'(out_valid), 64'd1);
    chk("zext12_value", 64'(extended), 64'h0000_0000_0000_0FFF);
    release_result();
    chk("release_idle", 64'(out_valid), 64'd0);

    // Sign extensions
    cyc(1'b1, 3'd3, 29'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sext12_value", 64'(extended), 64'hFFFF_FFFF_FFFF_F800);
    release_result();
    cyc(1'b1, 3'd4, 29'h40000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sext19_value", 64'(extended), 64'hFFFF_FFFF_FFFC_0000);
    release_result();

`ifdef IMM_EXT_WIDE_EN
    // Four wide beats fill the result exactly
    cyc(1'b1, 3'd5, 29'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 29'h5678, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 29'h9ABC, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wide_pending_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 3'd5, 29'hDEF0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wide4_value", 64'(extended), 64'h1234_5678_9ABC_DEF0);
    chk("wide4_overflow", 64'(overflow), 64'd0);
    release_result();
    // Five beats lose the oldest chunk
    for (int i = 1; i <= 5; i++)
      cyc(1'b1, 3'd5, 29'(i), (i == 5), 1'b0, 1'b0, 1'b0);
    chk("wide5_value", 64'(extended), 64'h0002_0003_0004_0005);
    chk("wide5_overflow", 64'(overflow), 64'd1);
    release_result();
`else
    // Selector 101 is reserved: result 0 after one cycle
    cyc(1'b1, 3'd5, 29'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rsvd5_valid", 64'(out_valid), 64'd1);
    chk("rsvd5_value", 64'(extended), 64'd0);
    chk("rsvd5_overflow", 64'(overflow), 64'd0);
    release_result();
`endif

    // Back-pressure: result held stable, no accept while held or on release
    cyc(1'b1, 3'd2, 29'h0ABCDEF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'd0, 29'h3FFC, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_value", 64'(extended), 64'h0000_0000_00AB_CDEF);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    cyc(1'b1, 3'd0, 29'h3FFC, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    chk("hold_release_ready", 64'(in_ready), 64'd1);

    // Flush after two wide beats, then a normal request
    cyc(1'b1, 3'd5, 29'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 29'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 3'd5, 29'h3333, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 3'd2, 29'h1FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_flush_value", 64'(extended), 64'h0000_0000_1FFF_FFFF);
    // Reset while holding
    cyc(1'b0, 3'd0, 29'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_in_hold_valid", 64'(out_valid), 64'd0);
    chk("rst_in_hold_value", 64'(extended), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      s = (r > 7) ? 3'd5 : 3'(r);
      cyc(($urandom_range(0, 9) < 7), s, 29'($urandom), ($urandom_range(0, 9) < 3),
          $urandom_range(0, 1) == 1, ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 2));
    end

    @(negedge clk);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_ext_unit.md
IMM_EXT_UNIT -- requirements
Module: imm_ext_unit

Interface
REQ-001 SHALL have parameter N, default 64, output width in bits; legal values are multiples of 16 and at least 32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-006 SHALL have port value  input  29  instruction immediate field.
REQ-007 SHALL have port ext_selector  input  3  extension mode.
REQ-008 SHALL have port last  input  1  final beat of a wide immediate; ignored in other modes.
REQ-009 SHALL have port flush  input  1  abort current operation.
REQ-010 SHALL have port out_valid  output  1  extended holds a result.
REQ-011 SHALL have port out_ready  input  1  consumer takes result when out_valid&out_ready.
REQ-012 SHALL have port extended  output  N  extended value.
REQ-013 SHALL have port overflow  output  1  wide immediate exceeded N bits; valid with out_valid.

Function
REQ-014 SHALL implement states IDLE, ACCUM and HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-015 SHALL decode ext_selector as follows: 000 zero-extends value[13:2]; 001 zero-extends value[18:0]; 010 zero-extends value[28:0]; 011 sign-extends value[13:2]; 100 sign-extends value[18:0]; 101 is a wide beat; 110 and 111 produce 0.
REQ-016 SHALL, on an accepted non-wide request in IDLE, register the result and enter HOLD, giving out_valid exactly one cycle after acceptance.
REQ-017 SHALL, on an accepted wide beat, set acc to (acc<<16)|value[15:0] truncated to N bits and increment the beat counter.
REQ-018 SHALL go IDLE->ACCUM on a first wide beat with last=0, and go to HOLD on any wide beat with last=1.
REQ-019 SHALL, in ACCUM, treat an accepted non-wide selector as the terminating beat: discard acc and handle it as in REQ-016.
REQ-020 SHALL set overflow when the beat count exceeds N/16; the MSBs shifted out are lost.
REQ-021 SHALL hold extended and overflow stable in HOLD until out_ready=1, then return to IDLE with no same-cycle accept.
REQ-022 SHALL give flush priority over in_valid and out_ready: the next state is IDLE, acc and counter clear, and out_valid=0.
REQ-023 SHALL keep the beat counter at $clog2(N/16)+1 bits, saturating at its maximum value.

Reset
REQ-024 SHALL, while rst=1, force IDLE, acc=0, counter=0, extended=0, out_valid=0 and overflow=0 on the next edge, including mid-ACCUM and mid-HOLD.
REQ-025 SHALL give rst priority over flush and all handshakes.

Configuration
REQ-026 SHALL support macro IMM_EXT_WIDE_EN; when it is defined, selector 101 behaves as specified in REQ-017..REQ-020.
REQ-027 SHALL, when IMM_EXT_WIDE_EN is undefined, omit the ACCUM state, acc and counter, treat selector 101 as reserved (result 0, latency 1), and tie overflow to 0.

Structure
REQ-028 SHALL place ext_sel_t (3-bit enum), state_t, CHUNK_W=16 and FIELD_W=29 in package imm_ext_pkg.
REQ-029 SHALL place the combinational single-field extension (REQ-015, non-wide modes) in sub-module imm_ext_decode, parameterised by N.

Verification (N=64)
REQ-030 SHALL test: sel=000, value=29'h3FFC -> one cycle later out_valid=1, extended=64'h0000_0000_0000_0FFF.
REQ-031 SHALL test: sel=011, value=29'h2000 -> extended=64'hFFFF_FFFF_FFFF_F800; sel=100, value=29'h40000 -> 64'hFFFF_FFFF_FFFC_0000.
REQ-032 SHALL test: wide beats 1234, 5678, 9ABC, DEF0, last on the 4th -> extended=64'h1234_5678_9ABC_DEF0, overflow=0.
REQ-033 SHALL test: five wide beats 0001..0005, last on the 5th -> extended=64'h0002_0003_0004_0005, overflow=1.
REQ-034 SHALL test: a result with out_ready=0 for 3 cycles -> extended stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 SHALL test: flush after 2 wide beats -> IDLE, then sel=010, value=29'h1FFFFFFF yields 64'h0000_0000_1FFF_FFFF; rst in HOLD -> out_valid=0 next cycle.
